// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding mux selects and MDU FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/hazard_mc_unit_mdu_stall_fsm.sv
// Multi-cycle MDU stall sequencer: stalls the front of the pipe for MDU_LAT cycles,
// then spends one DONE cycle in E while the result is valid.
module mdu_stall_fsm
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic MduStartE,
  output logic mduStall,
  output logic MduBusy,
  output logic MduDoneE
);

  // The IDLE start cycle is the first stall cycle, so BUSY only counts MDU_LAT-1 more.
  localparam logic [7:0] CNT_INIT = 8'(MDU_LAT - 2);

  mdu_state_t stateReg;
  logic [7:0] cntReg;
  logic       busyReg;
  logic       doneReg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg <= IDLE;
      cntReg   <= 8'd0;
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (MduStartE) begin
            stateReg <= BUSY;
            cntReg   <= CNT_INIT;
            busyReg  <= 1'b1;
          end
          doneReg <= 1'b0;
        end
        BUSY: begin
          if (cntReg == 8'd0) begin
            stateReg <= DONE;
            doneReg  <= 1'b1;
          end else begin
            cntReg <= cntReg - 8'd1;
          end
        end
        DONE: begin
          // The finishing op is still in E here, so its start request must not retrigger.
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          doneReg  <= 1'b0;
        end
        default: begin
          stateReg <= IDLE;
          busyReg  <= 1'b0;
          doneReg  <= 1'b0;
        end
      endcase
    end
  end

  assign mduStall = !reset && (((stateReg == IDLE) && MduStartE) || (stateReg == BUSY));
  assign MduBusy  = busyReg && !reset;
  assign MduDoneE = doneReg && !reset;

endmodule

// File: rtl/hazard_mc_unit.sv
// Pipeline hazard unit: E-stage forwarding, load-use stall, branch flush,
// multi-cycle MDU stall and a saturating stall-cycle counter.
module hazard_mc_unit
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCSrcE,
  input  logic              ResultSrcEb0,
  input  logic              MduStartE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_W-1:0]  Rs1D,
  input  logic [REG_W-1:0]  Rs2D,
  input  logic [REG_W-1:0]  Rs1E,
  input  logic [REG_W-1:0]  Rs2E,
  input  logic [REG_W-1:0]  RdE,
  input  logic [REG_W-1:0]  RdM,
  input  logic [REG_W-1:0]  RdW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MduBusy,
  output logic              MduDoneE,
  output logic [PERF_W-1:0] StallCycles
);

  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic              mduStall;
  logic              lwStall;
  logic [PERF_W-1:0] stallCyclesReg;

  // M is younger than W, so its value wins when both target the same register; x0 never forwards.
  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] rs, input logic rst);
    if (rst || rs == '0)
      return FWD_RF;
    else if (RegWriteM && RdM == rs)
      return FWD_M;
    else if (RegWriteW && RdW == rs)
      return FWD_W;
    else
      return FWD_RF;
  endfunction

  assign ForwardAE = fwdSel(Rs1E, reset);
  assign ForwardBE = fwdSel(Rs2E, reset);

  mdu_stall_fsm #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_fsm (
    .clk       (clk),
    .reset     (reset),
    .MduStartE (MduStartE),
    .mduStall  (mduStall),
    .MduBusy   (MduBusy),
    .MduDoneE  (MduDoneE)
  );

  assign lwStall = !reset && ResultSrcEb0 && (RdE != '0) && ((Rs1D == RdE) || (Rs2D == RdE));

  // An MDU stall freezes E, so a coincident load-use bubble or redirect must not clear it.
  assign StallE = mduStall;
  assign StallF = mduStall || lwStall;
  assign StallD = mduStall || lwStall;
  assign FlushM = reset || mduStall;
  assign FlushE = reset || ((lwStall || PCSrcE) && !mduStall);
  assign FlushD = reset || (PCSrcE && !mduStall);

  always_ff @(posedge clk) begin
    if (reset)
      stallCyclesReg <= '0;
    else if (StallF && stallCyclesReg != PERF_MAX)
      stallCyclesReg <= stallCyclesReg + PERF_W'(1);
  end

  assign StallCycles = stallCyclesReg;

endmodule

// File: tb/tb_hazard_mc_unit.sv
// Bench for hazard_mc_unit: two instances (MDU_LAT=4/PERF_W=32 and MDU_LAT=2/PERF_W=3)
// driven together and compared every cycle against an op-age reference model.
module tb_hazard_mc_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       PCSrcE, ResultSrcEb0, MduStartE, RegWriteM, RegWriteW;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;

  logic [1:0] fA [2];
  logic [1:0] fB [2];
  logic       sF [2], sD [2], sE [2], flD [2], flE [2], flM [2], busy [2], done [2];
  logic [31:0] scA;
  logic [2:0]  scB;

  int total = 0;
  int bad   = 0;

  int lat [2] = '{4, 2};
  int age [2];
  int perf [2];

  always #5 clk = ~clk;

  hazard_mc_unit #(.REG_W(5), .MDU_LAT(4), .PERF_W(32)) dutA (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .ResultSrcEb0(ResultSrcEb0),
    .MduStartE(MduStartE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ForwardAE(fA[0]), .ForwardBE(fB[0]), .StallF(sF[0]), .StallD(sD[0]), .StallE(sE[0]),
    .FlushD(flD[0]), .FlushE(flE[0]), .FlushM(flM[0]), .MduBusy(busy[0]), .MduDoneE(done[0]),
    .StallCycles(scA)
  );

  hazard_mc_unit #(.REG_W(5), .MDU_LAT(2), .PERF_W(3)) dutB (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .ResultSrcEb0(ResultSrcEb0),
    .MduStartE(MduStartE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .ForwardAE(fA[1]), .ForwardBE(fB[1]), .StallF(sF[1]), .StallD(sD[1]), .StallE(sE[1]),
    .FlushD(flD[1]), .FlushE(flE[1]), .FlushM(flM[1]), .MduBusy(busy[1]), .MduDoneE(done[1]),
    .StallCycles(scB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Age of the MDU op in E this cycle (0 = start cycle), -1 when none is in flight.
  function automatic int effAge(int i);
    return (!reset && age[i] < 0 && MduStartE) ? 0 : age[i];
  endfunction

  function automatic logic [1:0] refFwd(logic [4:0] rs);
    if (reset || rs == 5'd0) return 2'b00;
    if (RegWriteM && RdM == rs) return 2'b10;
    if (RegWriteW && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic cycle();
    int   e [2];
    logic ms, lw, stf [2];
    int   expCnt;
    @(negedge clk);
    lw = !reset && ResultSrcEb0 && RdE != 5'd0 && (Rs1D == RdE || Rs2D == RdE);
    for (int i = 0; i < 2; i++) begin
      e[i]   = effAge(i);
      ms     = !reset && e[i] >= 0 && e[i] < lat[i];
      stf[i] = ms | lw;
      expCnt = (i == 1 && perf[i] > 7) ? 7 : perf[i];
      check($sformatf("fwdA%0d", i), 32'(fA[i]), 32'(refFwd(Rs1E)));
      check($sformatf("fwdB%0d", i), 32'(fB[i]), 32'(refFwd(Rs2E)));
      check($sformatf("stallF%0d", i), 32'(sF[i]), 32'(stf[i]));
      check($sformatf("stallD%0d", i), 32'(sD[i]), 32'(stf[i]));
      check($sformatf("stallE%0d", i), 32'(sE[i]), 32'(ms));
      check($sformatf("flushM%0d", i), 32'(flM[i]), 32'(reset | ms));
      check($sformatf("flushE%0d", i), 32'(flE[i]), 32'(reset | ((lw | PCSrcE) & !ms)));
      check($sformatf("flushD%0d", i), 32'(flD[i]), 32'(reset | (PCSrcE & !ms)));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(!reset && age[i] >= 1));
      check($sformatf("done%0d", i), 32'(done[i]), 32'(!reset && e[i] == lat[i]));
      check($sformatf("perf%0d", i), (i == 0) ? scA : 32'(scB), 32'(expCnt));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        age[i]  = -1;
        perf[i] = 0;
      end else begin
        if (stf[i]) perf[i]++;
        if (e[i] >= 0) begin
          age[i] = e[i] + 1;
          if (age[i] > lat[i]) age[i] = -1;
        end
      end
    end
    #1;
  endtask

  task automatic idleInputs();
    PCSrcE = 0; ResultSrcEb0 = 0; MduStartE = 0; RegWriteM = 0; RegWriteW = 0;
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
  endtask

  initial begin
    logic blockPc;
    age  = '{-1, -1};
    perf = '{0, 0};
    idleInputs();
    reset = 1;
    @(posedge clk); #1;
    cycle(); cycle();
    reset = 0;
    cycle();

    // Forwarding: M then W, M priority, x0 never forwards
    Rs1E = 1; RdM = 1; RegWriteM = 1; Rs2E = 2; RdW = 2; RegWriteW = 1;
    cycle();
    RdM = 2; cycle();
    Rs1E = 0; cycle();

    // Load-use plus taken branch, then RdE=x0
    idleInputs();
    Rs1D = 3; RdE = 3; ResultSrcEb0 = 1; PCSrcE = 1;
    cycle();
    RdE = 0; cycle();
    idleInputs();
    cycle();

    // Single MDU op held until done, then back-to-back ops from a clean counter
    reset = 1; cycle(); reset = 0;
    MduStartE = 1;
    for (int n = 0; n < 5; n++) cycle();
    MduStartE = 0; cycle();
    reset = 1; cycle(); reset = 0;
    MduStartE = 1;
    for (int n = 0; n < 10; n++) cycle();
    check("b2b_cnt", scA, 32'd8);
    MduStartE = 0; cycle();

    // Reset in BUSY abandons the op; a fresh op then stalls the full length
    MduStartE = 1; cycle(); cycle();
    reset = 1; cycle(); reset = 0;
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_cnt", scA, 32'd0);
    for (int n = 0; n < 5; n++) cycle();
    MduStartE = 0; cycle();

    // Saturation of the 3-bit counter under a sustained load-use stall
    reset = 1; cycle(); reset = 0;
    ResultSrcEb0 = 1; RdE = 7; Rs2D = 7;
    for (int n = 0; n < 10; n++) cycle();
    check("sat_cnt", 32'(scB), 32'd7);
    idleInputs(); cycle();

    // Random traffic; redirects are never issued while either instance expects an MDU stall
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 39) == 0);
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      ResultSrcEb0 = 1'($urandom_range(0, 1));
      MduStartE    = ($urandom_range(0, 3) == 0);
      Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
      RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      blockPc = 0;
      for (int i = 0; i < 2; i++)
        if (!reset && effAge(i) >= 0 && effAge(i) < lat[i]) blockPc = 1;
      PCSrcE = !blockPc && ($urandom_range(0, 3) == 0);
      cycle();
      check("illegal_pc", 32'(PCSrcE & (sE[0] | sE[1])), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
